cache_way_sel: RTL and testbench

CACHE_WAY_SEL -- requirements
Module: cache_way_sel

---
 rtl/cache_way_sel_pkg.sv | 24 ++
 rtl/cache_way_sel_plru.sv | 26 ++
 rtl/cache_way_sel.sv | 180 ++++++++++++++++++
 tb/tb_cache_way_sel.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_way_sel_pkg.sv
// Shared widths, FSM encodings and helpers
// for the cache way-select stage.
package cache_way_sel_pkg;

  localparam int TAG_WIDTH    = 20;
  localparam int INDEX_WIDTH  = 6;
  localparam int OFFSET_WIDTH = 4;
  localparam int WORD_WIDTH   = 32;
  localparam int WAY_NUM      = 4;
  localparam int SET_NUM      = 1 << INDEX_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  typedef logic [1:0] way_t;

  function automatic logic [WAY_NUM-1:0]
    way_onehot(input way_t w);
    way_onehot    = '0;
    way_onehot[w] = 1'b1;
  endfunction

endpackage

// File: rtl/cache_way_sel_plru.sv
// 4-way tree PLRU: victim pick and update.
// bits = {b0,b1,b2}; b0 is the root.
module plru4
  import cache_way_sel_pkg::*;
(
  input  logic [2:0] bits,
  input  way_t       acc_way,
  output way_t       victim,
  output logic [2:0] bits_next
);

  // victim walk and post-access tree bits
  always_comb begin
    if (bits[2])
      victim = bits[0] ? 2'd3 : 2'd2;
    else
      victim = bits[1] ? 2'd1 : 2'd0;
    bits_next    = bits;
    bits_next[2] = ~acc_way[1];
    if (!acc_way[1])
      bits_next[1] = (acc_way == 2'd0);
    else
      bits_next[0] = (acc_way == 2'd2);
  end

endmodule

// File: rtl/cache_way_sel.sv
// Tag compare, miss/refill FSM and per-set
// PLRU storage for a 4-way cache.
module cache_way_sel
  import cache_way_sel_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    wr,
  input  logic [TAG_WIDTH-1:0]    tag,
  input  logic [INDEX_WIDTH-1:0]  index,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [WORD_WIDTH-1:0]   store_data,
  input  logic [TAG_WIDTH-1:0]    way0_tag,
  input  logic [TAG_WIDTH-1:0]    way1_tag,
  input  logic [TAG_WIDTH-1:0]    way2_tag,
  input  logic [TAG_WIDTH-1:0]    way3_tag,
  input  logic [WAY_NUM-1:0]      way_valid,
  input  logic                    refill_ack,
  output logic [WAY_NUM-1:0]      hit_en,
  output logic                    way0_replace_en,
  output logic                    way1_replace_en,
  output logic                    way2_replace_en,
  output logic                    way3_replace_en,
  output logic                    wr_o,
  output logic [INDEX_WIDTH-1:0]  index_o,
  output logic [OFFSET_WIDTH-1:0] offset_o,
  output logic [WORD_WIDTH-1:0]   store_data_o,
  output logic                    refill_req,
  output logic [INDEX_WIDTH-1:0]  refill_index,
  output logic [TAG_WIDTH-1:0]    refill_tag,
  output logic                    tag_we,
  output way_t                    tag_wway,
  output logic                    stall
);

  logic [1:0]           state;
  logic [3*SET_NUM-1:0] plru_q;
  way_t                 victim_q;

  logic [WAY_NUM-1:0] hits;
  logic               hit;
  way_t               hit_way;
  way_t               plru_victim;
  way_t               victim;
  way_t               upd_way;
  logic [2:0]         upd_in;
  logic [2:0]         upd_out;
  logic               idle;
  logic [WAY_NUM-1:0] repl_oh;

  assign idle = (state == IDLE);

  // per-way tag compare qualified by valid
  always_comb begin
    hits[0] = way_valid[0] & (way0_tag == tag);
    hits[1] = way_valid[1] & (way1_tag == tag);
    hits[2] = way_valid[2] & (way2_tag == tag);
    hits[3] = way_valid[3] & (way3_tag == tag);
    hit     = |hits;
  end

  // lowest-numbered hit way wins
  always_comb begin
    hit_way = 2'd0;
    if (hits[0])      hit_way = 2'd0;
    else if (hits[1]) hit_way = 2'd1;
    else if (hits[2]) hit_way = 2'd2;
    else if (hits[3]) hit_way = 2'd3;
  end

  // fill empty ways first, else PLRU victim
  always_comb begin
    if (!way_valid[0])      victim = 2'd0;
    else if (!way_valid[1]) victim = 2'd1;
    else if (!way_valid[2]) victim = 2'd2;
    else if (!way_valid[3]) victim = 2'd3;
    else                    victim = plru_victim;
  end

  // one PLRU port: lookup set in IDLE,
  // refill set while completing a miss
  always_comb begin
    if (idle) begin
      upd_in  = plru_q[3*index +: 3];
      upd_way = hit_way;
    end else begin
      upd_in  = plru_q[3*refill_index +: 3];
      upd_way = victim_q;
    end
  end

  plru4 u_plru (
    .bits      (upd_in),
    .acc_way   (upd_way),
    .victim    (plru_victim),
    .bits_next (upd_out)
  );

  // PLRU storage, touched on hit or fill
  always_ff @(posedge clk) begin
    if (rst)
      plru_q <= '0;
    else if (idle && req_valid && hit)
      plru_q[3*index +: 3] <= upd_out;
    else if (state == MISS && refill_ack)
      plru_q[3*refill_index +: 3] <= upd_out;
  end

  assign way0_replace_en = repl_oh[0];
  assign way1_replace_en = repl_oh[1];
  assign way2_replace_en = repl_oh[2];
  assign way3_replace_en = repl_oh[3];

  // lookup / miss / fill state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      victim_q     <= '0;
      hit_en       <= '0;
      repl_oh      <= '0;
      wr_o         <= 1'b0;
      index_o      <= '0;
      offset_o     <= '0;
      store_data_o <= '0;
      refill_req   <= 1'b0;
      refill_index <= '0;
      refill_tag   <= '0;
      tag_we       <= 1'b0;
      tag_wway     <= '0;
      stall        <= 1'b0;
    end else begin
      hit_en   <= '0;
      repl_oh  <= '0;
      tag_we   <= 1'b0;
      tag_wway <= '0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr_o         <= wr;
            index_o      <= index;
            offset_o     <= offset;
            store_data_o <= store_data;
            if (hit) begin
              hit_en <= way_onehot(hit_way);
            end else begin
              state        <= MISS;
              refill_req   <= 1'b1;
              stall        <= 1'b1;
              refill_index <= index;
              refill_tag   <= tag;
              victim_q     <= victim;
            end
          end
        end
        MISS: begin
          if (refill_ack) begin
            state      <= FILL;
            refill_req <= 1'b0;
            repl_oh    <= way_onehot(victim_q);
            tag_we     <= 1'b1;
            tag_wway   <= victim_q;
          end
        end
        FILL: begin
          state        <= IDLE;
          stall        <= 1'b0;
          refill_index <= '0;
          refill_tag   <= '0;
        end
        default: begin
          state      <= IDLE;
          refill_req <= 1'b0;
          stall      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_way_sel.sv
// Directed scoreboard bench for cache_way_sel.
// Expected records are queued per driven cycle.
module tb_cache_way_sel;
  import cache_way_sel_pkg::*;

  localparam int TW = TAG_WIDTH;
  localparam int IW = INDEX_WIDTH;
  localparam int OW = OFFSET_WIDTH;
  localparam int DW = WORD_WIDTH;

  typedef struct packed {
    logic [3:0]    hit;
    logic [3:0]    repl;
    logic          rreq;
    logic [IW-1:0] ridx;
    logic [TW-1:0] rtag;
    logic          twe;
    logic [1:0]    twway;
    logic          stall;
    logic          wr;
    logic [IW-1:0] idx;
    logic [OW-1:0] off;
    logic [DW-1:0] sd;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          wr;
  logic [TW-1:0] tag;
  logic [IW-1:0] index;
  logic [OW-1:0] offset;
  logic [DW-1:0] store_data;
  logic [TW-1:0] way0_tag;
  logic [TW-1:0] way1_tag;
  logic [TW-1:0] way2_tag;
  logic [TW-1:0] way3_tag;
  logic [3:0]    way_valid;
  logic          refill_ack;
  logic [3:0]    hit_en;
  logic          way0_replace_en;
  logic          way1_replace_en;
  logic          way2_replace_en;
  logic          way3_replace_en;
  logic          wr_o;
  logic [IW-1:0] index_o;
  logic [OW-1:0] offset_o;
  logic [DW-1:0] store_data_o;
  logic          refill_req;
  logic [IW-1:0] refill_index;
  logic [TW-1:0] refill_tag;
  logic          tag_we;
  logic [1:0]    tag_wway;
  logic          stall;

  int n_cmp = 0;
  int n_err = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  cache_way_sel dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .wr              (wr),
    .tag             (tag),
    .index           (index),
    .offset          (offset),
    .store_data      (store_data),
    .way0_tag        (way0_tag),
    .way1_tag        (way1_tag),
    .way2_tag        (way2_tag),
    .way3_tag        (way3_tag),
    .way_valid       (way_valid),
    .refill_ack      (refill_ack),
    .hit_en          (hit_en),
    .way0_replace_en (way0_replace_en),
    .way1_replace_en (way1_replace_en),
    .way2_replace_en (way2_replace_en),
    .way3_replace_en (way3_replace_en),
    .wr_o            (wr_o),
    .index_o         (index_o),
    .offset_o        (offset_o),
    .store_data_o    (store_data_o),
    .refill_req      (refill_req),
    .refill_index    (refill_index),
    .refill_tag      (refill_tag),
    .tag_we          (tag_we),
    .tag_wway        (tag_wway),
    .stall           (stall)
  );

  function automatic obs_t base(
    input logic          w,
    input logic [IW-1:0] i,
    input logic [OW-1:0] o,
    input logic [DW-1:0] d
  );
    base     = '0;
    base.wr  = w;
    base.idx = i;
    base.off = o;
    base.sd  = d;
  endfunction

  function automatic obs_t sample();
    sample.hit   = hit_en;
    sample.repl  = {way3_replace_en, way2_replace_en,
                    way1_replace_en, way0_replace_en};
    sample.rreq  = refill_req;
    sample.ridx  = refill_index;
    sample.rtag  = refill_tag;
    sample.twe   = tag_we;
    sample.twway = tag_wway;
    sample.stall = stall;
    sample.wr    = wr_o;
    sample.idx   = index_o;
    sample.off   = offset_o;
    sample.sd    = store_data_o;
  endfunction

  // push expectation, clock once, pop and compare
  task automatic cyc(input obs_t e, input string nm);
    obs_t  o;
    obs_t  x;
    string n;
    exp_q.push_back(e);
    tag_q.push_back(nm);
    @(posedge clk);
    #1;
    o = sample();
    x = exp_q.pop_front();
    n = tag_q.pop_front();
    n_cmp++;
    assert (o === x) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             n, o, x);
    end
  endtask

  obs_t e;
  obs_t m;
  obs_t f;
  obs_t z;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    wr         = 1'b0;
    tag        = '0;
    index      = '0;
    offset     = '0;
    store_data = '0;
    way0_tag   = '0;
    way1_tag   = '0;
    way2_tag   = '0;
    way3_tag   = '0;
    way_valid  = '0;
    refill_ack = 1'b0;
    z = base(1'b0, '0, '0, '0);

    #2;
    cyc(z, "reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(z, "idle");

    // single valid hit in way 2
    index      = 6'd5;
    tag        = 20'h1A;
    way_valid  = 4'b0100;
    way0_tag   = 20'h1A;
    way1_tag   = 20'h1A;
    way2_tag   = 20'h1A;
    way3_tag   = 20'h1B;
    wr         = 1'b1;
    offset     = 4'd3;
    store_data = 32'hDEADBEEF;
    req_valid  = 1'b1;
    e = base(1'b1, 6'd5, 4'd3, 32'hDEADBEEF);
    e.hit = 4'b0100;
    cyc(e, "hit_way2");

    req_valid = 1'b0;
    e.hit = 4'b0000;
    cyc(e, "idle_hold");
    refill_ack = 1'b1;
    cyc(e, "ack_in_idle");
    refill_ack = 1'b0;

    // miss, ways 0/1 valid -> victim way 2
    index      = 6'd3;
    tag        = 20'h55;
    way_valid  = 4'b0011;
    way0_tag   = 20'h01;
    way1_tag   = 20'h02;
    way2_tag   = 20'h55;
    way3_tag   = 20'h55;
    wr         = 1'b0;
    offset     = 4'd1;
    store_data = 32'h11112222;
    req_valid  = 1'b1;
    m = base(1'b0, 6'd3, 4'd1, 32'h11112222);
    m.rreq  = 1'b1;
    m.ridx  = 6'd3;
    m.rtag  = 20'h55;
    m.stall = 1'b1;
    cyc(m, "miss_idx3");

    // a hitting request while stalled is ignored
    index      = 6'd5;
    tag        = 20'h1A;
    way_valid  = 4'b0100;
    way2_tag   = 20'h1A;
    wr         = 1'b1;
    offset     = 4'd3;
    store_data = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++)
      cyc(m, "miss_wait");

    refill_ack = 1'b1;
    f = m;
    f.rreq  = 1'b0;
    f.repl  = 4'b0100;
    f.twe   = 1'b1;
    f.twway = 2'd2;
    cyc(f, "fill_way2");
    refill_ack = 1'b0;

    e = base(1'b0, 6'd3, 4'd1, 32'h11112222);
    cyc(e, "fill_exit");
    e = base(1'b1, 6'd5, 4'd3, 32'hDEADBEEF);
    e.hit = 4'b0100;
    cyc(e, "first_after_fill");
    req_valid = 1'b0;

    // all valid, fresh PLRU: way 0 then way 2
    index      = 6'd7;
    tag        = 20'h300;
    way_valid  = 4'b1111;
    way0_tag   = 20'h301;
    way1_tag   = 20'h302;
    way2_tag   = 20'h303;
    way3_tag   = 20'h304;
    wr         = 1'b0;
    offset     = 4'd0;
    store_data = 32'hCAFE0000;
    req_valid  = 1'b1;
    m = base(1'b0, 6'd7, 4'd0, 32'hCAFE0000);
    m.rreq  = 1'b1;
    m.ridx  = 6'd7;
    m.rtag  = 20'h300;
    m.stall = 1'b1;
    cyc(m, "miss_idx7_a");
    req_valid = 1'b0;
    cyc(m, "miss_idx7_wait");
    refill_ack = 1'b1;
    f = m;
    f.rreq  = 1'b0;
    f.repl  = 4'b0001;
    f.twe   = 1'b1;
    f.twway = 2'd0;
    cyc(f, "fill_idx7_way0");
    refill_ack = 1'b0;
    e = base(1'b0, 6'd7, 4'd0, 32'hCAFE0000);
    cyc(e, "idle_idx7_a");

    req_valid = 1'b1;
    cyc(m, "miss_idx7_b");
    req_valid  = 1'b0;
    refill_ack = 1'b1;
    f = m;
    f.rreq  = 1'b0;
    f.repl  = 4'b0100;
    f.twe   = 1'b1;
    f.twway = 2'd2;
    cyc(f, "fill_idx7_way2");
    refill_ack = 1'b0;
    cyc(e, "idle_idx7_b");

    // double hit in ways 1 and 3
    index      = 6'd9;
    tag        = 20'h77;
    way_valid  = 4'b1111;
    way0_tag   = 20'h70;
    way1_tag   = 20'h77;
    way2_tag   = 20'h72;
    way3_tag   = 20'h77;
    wr         = 1'b1;
    offset     = 4'd2;
    store_data = 32'h0BADF00D;
    req_valid  = 1'b1;
    e = base(1'b1, 6'd9, 4'd2, 32'h0BADF00D);
    e.hit = 4'b0010;
    cyc(e, "multi_hit");
    req_valid = 1'b0;

    // reset aborts an outstanding refill
    index      = 6'd10;
    tag        = 20'h99;
    way_valid  = 4'b0000;
    wr         = 1'b0;
    offset     = 4'd0;
    store_data = 32'h0;
    req_valid  = 1'b1;
    m = base(1'b0, 6'd10, 4'd0, 32'h0);
    m.rreq  = 1'b1;
    m.ridx  = 6'd10;
    m.rtag  = 20'h99;
    m.stall = 1'b1;
    cyc(m, "miss_idx10");
    req_valid = 1'b0;
    rst = 1'b1;
    cyc(z, "reset_abort");
    rst = 1'b0;
    refill_ack = 1'b1;
    cyc(z, "ack_after_abort");
    refill_ack = 1'b0;
    cyc(z, "idle_after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
